// File: rtl/enc_arb_nx.sv
// Registered N-input request arbiter/encoder with valid/ack hold.
// Fixed-priority or round-robin winner, one-hot grant and multi-hot flag.
module enc_arb_nx #(
   parameter int N    = 4,
   parameter int W    = 2,
   parameter int MODE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic [W-1:0] code,
   output logic [N-1:0] grant,
   output logic         valid,
   output logic         multi,
   output logic [W-1:0] ptr
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t       state;
   logic [W-1:0] nptr;
   logic [W-1:0] base;
   logic [W-1:0] win;
   logic [W:0]   sum;
   logic         hit;
   logic         go;
   logic         many;

   assign go   = en && (req != '0);
   assign many = (req & (req - N'(1))) != '0;
   assign nptr = (code == W'(N - 1)) ? '0 : code + W'(1);

   // On an ack in HOLD the search starts from the pointer about to be stored.
   always_comb begin
      base = '0;
      if (MODE == 1) begin
         base = (state == HOLD && ack) ? nptr : ptr;
      end
   end

   always_comb begin
      win = '0;
      hit = 1'b0;
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, base} + (W+1)'(i);
         if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
         end
         if (!hit && req[sum[W-1:0]]) begin
            hit = 1'b1;
            win = sum[W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         code  <= '0;
         grant <= '0;
         valid <= 1'b0;
         multi <= 1'b0;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state <= HOLD;
                  valid <= 1'b1;
                  code  <= win;
                  grant <= N'(1) << win;
                  multi <= many;
               end
            end
            HOLD: begin
               if (ack) begin
                  if (MODE == 1) begin
                     ptr <= nptr;
                  end
                  if (go) begin
                     code  <= win;
                     grant <= N'(1) << win;
                     multi <= many;
                  end else begin
                     state <= IDLE;
                     valid <= 1'b0;
                     grant <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/enc_arb_nx.md
Name: enc_arb_nx

Overview:
- Parametrised, registered successor to the 4-input one-hot-to-binary encoder.
- Accepts N request lines and selects one, by fixed priority or round-robin.
- Presents the winner's binary code and one-hot grant, held stable under a valid/ack handshake.
- Flags multi-hot inputs; sits between request sources and a consumer that needs one stable index at a time.

Parameters:
N, 4, number of request inputs (2..32)
W, 2, code width; must equal ceil(log2(N))
MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; when 0 no new capture starts
req  input  N  request lines, level-sensitive, any combination legal
ack  input  1  consumer accepts current code
code  output  W  binary index of granted request
grant  output  N  one-hot of granted request
valid  output  1  code/grant/multi are meaningful
multi  output  1  more than one req bit was high at capture
ptr  output  W  round-robin base pointer (debug; constant 0 when MODE=0)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset asserted at any time, including mid-grant, immediately forces:
  - code = 0, grant = 0, valid = 0, multi = 0, ptr = 0
  - FSM to IDLE.
- FSM states: IDLE, HOLD.
- IDLE:
  - If en = 1 and req != 0 at a rising edge, capture the winner, go to HOLD.
  - Registered outputs update on that edge, so valid rises 1 cycle after the qualifying req.
- Winner selection:
  - MODE=0: lowest set index.
  - MODE=1: first set index at or above ptr, searching upward and wrapping from N-1 to 0.
- Captured values:
  - code = winner index.
  - grant = 1 << winner.
  - multi = (popcount(req) > 1).
- HOLD:
  - code, grant and multi are frozen regardless of req changes. A request dropping after capture does not cancel the grant.
  - On ack = 1:
    - MODE=1: ptr <= (winner + 1) mod N. ptr is never updated outside an ack in HOLD.
    - If en = 1 and req != 0 on the same edge: capture the next winner immediately (back-to-back), stay in HOLD, valid stays 1. In MODE=1 the search uses the updated ptr. In MODE=1 the request just acked may win again only if it is the only set bit.
    - Otherwise: valid = 0, grant = 0, go to IDLE. code keeps its last value.
- ack while valid = 0 is ignored. ack in the same cycle as the capture edge from IDLE has no effect; ack counts only when sampled with valid = 1.
- en = 0 during HOLD does not drop valid; it only blocks the next capture.
- Single one-hot input with N=4 reproduces the legacy encoding: req 0001->0, 0010->1, 0100->2, 1000->3, multi = 0.
- ptr wraps modulo N for non-power-of-2 N (e.g. N=5: ptr 4 -> 0). Codes >= N never occur.

Test Plan:
- N=4, MODE=0, reset release, each one-hot req in turn with ack one cycle after valid -> code 0,1,2,3; grant = req; multi = 0; valid high exactly 1 cycle per request.
- MODE=0, req = 1010 held, ack every valid cycle -> code stays 1 every grant, multi = 1, valid continuous (back-to-back).
- MODE=1, req = 1111 held, ack every cycle -> code sequence 0,1,2,3,0; ptr sequence 0,1,2,3,0,1.
- Capture req = 0100, then drop req to 0000 before ack -> code = 2, valid held until ack, then valid = 0, grant = 0000.
- N=5, MODE=1, req = 10001 held, acked -> codes 0,4,0,4; ptr 1,0 (wrap at 5), 1.
- Assert rst_n = 0 mid-HOLD (code = 3), then release with req = 0 -> all outputs 0 immediately; FSM in IDLE; en = 0 with req = 1111 -> valid stays 0.
